// File: rtl/simon_sequence_player.sv
// Plays a stored Simon colour sequence on four LEDs with fixed on/off timing,
// fetching colour indices from a synchronous-read sequence RAM.
module simon_sequence_player #(
  parameter int ON_CYCLES  = 25000000,
  parameter int OFF_CYCLES = 12500000,
  parameter int ADDR_W     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   seq_len,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  output logic [3:0]        leds,
  output logic              busy,
  output logic              done
);

  localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, ON, OFF, DONE} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] index_reg;
  logic [ADDR_W:0]   len_reg;
  logic [TW-1:0]     timer_reg;
  logic              first_reg;
  logic [3:0]        onehot_next;
  logic              last_entry;

  // Colour i lights leds[3-i], matching the button vector ordering.
  for (genvar gi = 0; gi < 4; gi++) begin : g_decode
    assign onehot_next[3-gi] = (rd_data == 2'(gi));
  end

  assign last_entry = ({1'b0, index_reg} == (len_reg - 1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      index_reg <= '0;
      len_reg   <= '0;
      timer_reg <= '0;
      first_reg <= 1'b0;
      rd_addr   <= '0;
      leds      <= 4'b0000;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state_reg <= IDLE;
      first_reg <= 1'b0;
      leds      <= 4'b0000;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (seq_len == '0) begin
              done      <= 1'b1;
              state_reg <= DONE;
            end else begin
              len_reg   <= (seq_len > MAX_LEN) ? MAX_LEN : seq_len;
              index_reg <= '0;
              first_reg <= 1'b1;
              busy      <= 1'b1;
              state_reg <= FETCH;
            end
          end
        end
        // The first entry has no prefetched address yet, so FETCH spends one
        // extra cycle issuing it; later entries were addressed on OFF exit.
        FETCH: begin
          rd_addr <= index_reg;
          if (first_reg) first_reg <= 1'b0;
          else           state_reg <= LATCH;
        end
        LATCH: begin
          leds      <= onehot_next;
          timer_reg <= ON_LOAD;
          state_reg <= ON;
        end
        ON: begin
          if (timer_reg == '0) begin
            leds      <= 4'b0000;
            timer_reg <= OFF_LOAD;
            state_reg <= OFF;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        OFF: begin
          if (timer_reg == '0) begin
            if (last_entry) begin
              busy      <= 1'b0;
              done      <= 1'b1;
              state_reg <= DONE;
            end else begin
              index_reg <= index_reg + 1'b1;
              rd_addr   <= index_reg + 1'b1;
              state_reg <= FETCH;
            end
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          leds      <= 4'b0000;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_sequence_player.sv
// Directed bench for simon_sequence_player with ON=4, OFF=2, ADDR_W=3 and a
// small registered-read RAM model.
module tb_simon_sequence_player;
  localparam int ON = 4;
  localparam int OFF = 2;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW:0]   seq_len = '0;
  logic [AW-1:0] rd_addr;
  logic [1:0]    rd_data;
  logic [3:0]    leds;
  logic          busy;
  logic          done;

  logic [1:0] mem [8];

  typedef struct {
    logic [3:0] leds;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl [27];
  int checks = 0;
  int failures = 0;

  simon_sequence_player #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seq_len(seq_len),
    .rd_addr(rd_addr), .rd_data(rd_data), .leds(leds), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected {leds,busy,done} after start edge k for RAM {2,0,3}, length 3.
  task automatic fill_table();
    for (int k = 0; k < 27; k++) tbl[k] = '{4'b0000, 1'b1, 1'b0};
    for (int k = 3; k <= 6; k++)   tbl[k].leds = 4'b0010;
    for (int k = 11; k <= 14; k++) tbl[k].leds = 4'b1000;
    for (int k = 19; k <= 22; k++) tbl[k].leds = 4'b0001;
    tbl[25] = '{4'b0000, 1'b0, 1'b1};
    tbl[26] = '{4'b0000, 1'b0, 1'b0};
  endtask

  task automatic play(input bit disturb, input string tag);
    seq_len = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk($sformatf("%s[0]", tag), {26'd0, leds, busy, done}, {26'd0, tbl[0].leds, tbl[0].busy, tbl[0].done});
    for (int k = 1; k < 27; k++) begin
      if (disturb) begin
        start = (k == 4) || (k == 13) || (k == 20);
        seq_len = 4'd1;
      end
      tick();
      chk($sformatf("%s[%0d]", tag, k), {26'd0, leds, busy, done},
          {26'd0, tbl[k].leds, tbl[k].busy, tbl[k].done});
      if (k == 1) chk($sformatf("%s_addr0", tag), 32'(rd_addr), 32'd0);
    end
    start = 1'b0;
    seq_len = 4'd3;
  endtask

  task automatic run_long(input logic [AW:0] len, input string tag);
    int lit_run, dark_run, pulses, lit_bad, gap_bad, done_cnt, done_k;
    logic [7:0] addr_seen;
    lit_run = 0; dark_run = 0; pulses = 0; lit_bad = 0; gap_bad = 0;
    done_cnt = 0; done_k = -1; addr_seen = '0;
    seq_len = len;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 72; k++) begin
      tick();
      addr_seen[rd_addr] = 1'b1;
      if (done) begin
        done_cnt++;
        done_k = k;
      end
      if (leds == 4'b0100) begin
        if (lit_run == 0 && pulses > 0 && dark_run != 4) gap_bad++;
        lit_run++;
        dark_run = 0;
      end else if (leds == 4'b0000) begin
        if (lit_run > 0) begin
          pulses++;
          if (lit_run != 4) lit_bad++;
          lit_run = 0;
        end
        dark_run++;
      end else begin
        lit_bad++;
      end
    end
    chk($sformatf("%s_pulses", tag), 32'(pulses), 32'd8);
    chk($sformatf("%s_lit_len", tag), 32'(lit_bad), 32'd0);
    chk($sformatf("%s_gaps", tag), 32'(gap_bad), 32'd0);
    chk($sformatf("%s_done_cnt", tag), 32'(done_cnt), 32'd1);
    chk($sformatf("%s_done_at", tag), 32'(done_k), 32'd65);
    chk($sformatf("%s_addr_cover", tag), 32'(addr_seen), 32'hFF);
  endtask

  initial begin
    int done_seen;
    int bad;
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
    for (int i = 3; i < 8; i++) mem[i] = 2'd0;
    fill_table();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {25'd0, rd_addr, leds, busy, done}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_rst", {26'd0, leds, busy, done}, 32'd0);

    // Main playback against the table
    play(1'b0, "seq");

    // Zero-length start
    tick();
    seq_len = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0_done", {29'd0, leds == 4'b0000, busy, done}, {29'd0, 1'b1, 1'b0, 1'b1});
    chk("len0_addr", 32'(rd_addr), 32'd2);
    tick();
    chk("len0_pulse_end", {30'd0, busy, done}, 32'd0);
    chk("len0_addr_hold", 32'(rd_addr), 32'd2);

    // Abort during second ON period
    seq_len = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    chk("abort_pre_leds", 32'(leds), 32'b1000);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_outputs", {26'd0, leds, busy, done}, 32'd0);
    done_seen = 0;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done) done_seen++;
      if (leds != 4'b0000 || busy) bad++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    chk("abort_stays_idle", 32'(bad), 32'd0);

    // Replay from index 0 with start/seq_len disturbances while busy
    play(1'b1, "replay");

    // Asynchronous reset mid-ON
    tick();
    seq_len = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("rst_pre_leds", 32'(leds), 32'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_clear", {30'd0, leds == 4'b0000, busy}, {30'd0, 1'b1, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (leds != 4'b0000 || busy || done) bad++;
    end
    chk("post_rst_idle", 32'(bad), 32'd0);
    chk("post_rst_addr", 32'(rd_addr), 32'd0);

    // Full-length sequence and clamped length
    for (int i = 0; i < 8; i++) mem[i] = 2'd1;
    run_long(4'd8, "len8");
    tick();
    run_long(4'd15, "clamp");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simon_sequence_player.md
Name: simon_sequence_player

Overview:
- Output-side counterpart to the debounced button input path of the Simon game.
- Plays a stored colour sequence to the player by lighting the four LEDs one at a time with fixed on/off timing.
- Reads colour indices from the game's sequence RAM through a synchronous-read port.
- The game FSM starts playback with `start`; the block signals completion with a `done` pulse. LED bit ordering matches the button vector so the FSM compares like for like.

Parameters:
- ON_CYCLES, 25000000, clock cycles each LED stays lit; must be ≥ 1.
- OFF_CYCLES, 12500000, clock cycles all LEDs are dark after each colour; must be ≥ 1.
- ADDR_W, 5, sequence RAM address width; maximum length is 2^ADDR_W.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to play entries 0..seq_len-1; honoured only in IDLE.
- abort  input  1  synchronous stop; takes effect in any state.
- seq_len  input  ADDR_W+1  number of entries to play; sampled only when start is accepted.
- rd_addr  output  ADDR_W  sequence RAM read address; registered.
- rd_data  input  2  colour index from RAM; valid one cycle after rd_addr is presented.
- leds  output  4  LED drive, at most one bit set; colour i lights leds[3-i] (colour 0 → leds[3], colour 3 → leds[0]), same ordering as the button vector.
- busy  output  1  high while playback is in progress.
- done  output  1  one-cycle pulse when playback completes normally.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, leds=0, busy=0, done=0, rd_addr=0, index and timer=0. This holds mid-playback too; outputs clear without waiting for a clock edge.
- States: IDLE, FETCH, LATCH, ON, OFF, DONE. All outputs are registered.
- IDLE, start=1, seq_len≥1:
  - latch len=seq_len, index=0.
  - next state FETCH; busy=1 from this edge.
- IDLE, start=1, seq_len=0: go to DONE directly; no LED lights and no RAM read occurs.
- IDLE, start=0: stay in IDLE.
- start is ignored in every state other than IDLE. seq_len changes after acceptance have no effect.
- FETCH (1 cycle): rd_addr=index. Next state LATCH.
- LATCH (1 cycle): on exit, capture rd_data into leds as one-hot per the ordering rule and load timer=ON_CYCLES-1. Next state ON.
- ON: leds held. Timer decrements each cycle. On the edge where timer=0: leds←0, timer←OFF_CYCLES-1, next state OFF. LED is lit exactly ON_CYCLES cycles.
- OFF: leds=0, timer decrements. At timer=0:
  - if index==len-1, go to DONE;
  - otherwise index←index+1 and go to FETCH.
- Dark gap between consecutive colours is exactly OFF_CYCLES+2 cycles.
- DONE (1 cycle): done=1, busy=0, leds=0. Next state IDLE.
- Latency: start sampled at edge 0 → FETCH at edge 1 → LATCH at edge 2 → leds valid after edge 3.
- Full sequence duration from start edge to done high: len·(ON_CYCLES+OFF_CYCLES+2)+1 cycles.
- abort=1 in any state: next state IDLE, leds=0, busy=0, done=0. abort has priority over start and over timer expiry in the same cycle.
- A repeated colour (same index twice in a row) still shows the dark gap, so the player can count repeats.
- Length 2^ADDR_W plays every address 0..2^ADDR_W-1. Values of seq_len > 2^ADDR_W are clamped to 2^ADDR_W at acceptance.
- Timer width is clog2(max(ON_CYCLES,OFF_CYCLES)), minimum 1 bit. The index counter never wraps, because termination is tested against len-1.

Test Plan:
- ON=4, OFF=2, ADDR_W=3. RAM={2,0,3}, start with seq_len=3:
  - leds sequence 0010×4, 0000×4, 1000×4, 0000×4, 0001×4, 0000×2, then a done pulse.
  - busy is high throughout; done arrives 25 cycles after start.
- seq_len=0 start → done pulses on the edge after start; leds stay 0; rd_addr never changes.
- Assert abort during the second ON period → on the next edge leds=0, busy=0, state IDLE, no done pulse. A new start then replays from index 0.
- Pulse start again while busy, and drive seq_len to a different value during playback → no restart and no length change; original timing is preserved exactly.
- Drop rst_n asynchronously mid-ON → leds=0 and busy=0 before the next clock edge. After release, the block stays idle until start.
- ADDR_W=3, seq_len=8 with RAM all 1 → eight separate leds=0100 pulses separated by 4-cycle dark gaps; rd_addr covers 0..7; done fires once.
